// File: rtl/vga_frame_table_if.sv
// ---------------------------------------------------------------------------
// vga_frame_table_if
//   Pixel write stream into the VGA frame store.
//   wr_valid  producer -> store   pixel present on wr_data
//   wr_ready  store -> producer   store can take a pixel this cycle
//   wr_data   producer -> store   pixel value, PIXEL_W bits
//   wr_sof    producer -> store   this pixel is pixel 0 of a frame
//   master modport: pixel producer; slave modport: frame store.
// ---------------------------------------------------------------------------
interface vga_frame_table_if #(
  parameter int PIXEL_W = 2
) ();
  logic               wr_valid;
  logic               wr_ready;
  logic [PIXEL_W-1:0] wr_data;
  logic               wr_sof;

  modport master (
    output wr_valid,
    output wr_data,
    output wr_sof,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  wr_sof,
    output wr_ready
  );
endinterface

// File: rtl/vga_frame_table.sv
// ---------------------------------------------------------------------------
// vga_frame_table
//   Pixel frame store between a pixel producer and the VGA timing generator.
//   Pixels arrive on a valid/ready stream and are written linearly; the
//   display side walks the stored frame from h_sync/v_sync/bright, showing
//   every stored line V_SCALE times. With DOUBLE_BUF=1 the producer fills a
//   back bank and the banks swap at the falling edge of v_sync once the back
//   bank holds a complete frame.
//
// Ports
//   clk_25       in   pixel clock, rising edge
//   reset        in   synchronous, active-high
//   wr           slave write stream (wr_valid/wr_ready/wr_data/wr_sof)
//   h_sync       in   active-low horizontal sync
//   v_sync       in   active-low vertical sync
//   bright       in   display active region
//   pixel_out    out  displayed pixel (0 outside the active region)
//   pixel_valid  out  bright delayed by one cycle
//   frame_done   out  one-cycle pulse after the last pixel of a frame is taken
//   swapped      out  one-cycle pulse after a front/back bank swap
// ---------------------------------------------------------------------------
module vga_frame_table #(
  parameter int PIXEL_W    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_LINES    = 240,
  parameter int V_SCALE    = 2,
  parameter int DOUBLE_BUF = 0
) (
  input  logic               clk_25,
  input  logic               reset,
  vga_frame_table_if.slave   wr,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               bright,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid,
  output logic               frame_done,
  output logic               swapped
);

  localparam int FRAME_PIX = H_ACTIVE * V_LINES;
  localparam int PIX_AW    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int ADDR_W    = PIX_AW + DOUBLE_BUF;
  localparam int MEM_DEPTH = FRAME_PIX * (DOUBLE_BUF + 1);
  localparam int COL_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LINE_W    = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int REP_W     = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic              DBL       = (DOUBLE_BUF != 0);
  localparam logic [PIX_AW-1:0] LAST_PIX  = PIX_AW'(FRAME_PIX - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_LINES - 1);
  localparam logic [REP_W-1:0]  LAST_REP  = REP_W'(V_SCALE - 1);
  // Bank 1 lives directly above bank 0; in single-bank builds there is no offset.
  localparam logic [ADDR_W-1:0] BANK_OFF  = (DOUBLE_BUF != 0) ? ADDR_W'(FRAME_PIX)
                                                                : {ADDR_W{1'b0}};

  // Frame memory (both banks when double-buffered).
  logic [PIXEL_W-1:0] mem_q [MEM_DEPTH];

  // Write-side state
  logic [PIX_AW-1:0] waddr_q, waddr_d;
  logic              back_full_q, back_full_d;
  logic              front_q, front_d;
  logic              wr_ready_q, wr_ready_d;
  logic              frame_done_q, frame_done_d;
  logic              swapped_q, swapped_d;

  // Read-side state
  logic              v_sync_q, v_sync_d;
  logic              bright_q, bright_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [PIXEL_W-1:0] pixel_out_q, pixel_out_d;
  logic              pixel_valid_q, pixel_valid_d;

  // Combinational helpers
  logic              accept_s;
  logic [PIX_AW-1:0] wr_pix_s;
  logic              last_s;
  logic              vs_fall_s;
  logic              br_fall_s;
  logic              swap_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [ADDR_W-1:0] raddr_s;
  logic [PIXEL_W-1:0] rd_data_s;

  assign accept_s  = wr.wr_valid & wr_ready_q;
  // wr_sof restarts the frame: that pixel lands at address 0.
  assign wr_pix_s  = wr.wr_sof ? {PIX_AW{1'b0}} : waddr_q;
  assign last_s    = accept_s & (wr_pix_s == LAST_PIX);
  assign vs_fall_s = v_sync_q & ~v_sync;
  assign br_fall_s = bright_q & ~bright;
  // back_full_q is the state at the start of the cycle, so a frame completing
  // on the same cycle as vs_fall waits for the following vs_fall.
  assign swap_s    = DBL & vs_fall_s & back_full_q;

  // Writes go to the back bank (the bank not being displayed).
  assign wr_addr_s = ADDR_W'(wr_pix_s) + (front_q ? {ADDR_W{1'b0}} : BANK_OFF);
  assign raddr_s   = ADDR_W'(line_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(col_q)
                   + (front_q ? BANK_OFF : {ADDR_W{1'b0}});
  // Read sees the contents before this cycle's write lands (old data on collision).
  assign rd_data_s = mem_q[raddr_s];

  // Frame memory write port.
  always_ff @(posedge clk_25) begin
    if (accept_s && !reset) begin
      mem_q[wr_addr_s] <= wr.wr_data;
    end
  end

  // Write address, bank state and write-side pulses.
  always_comb begin
    waddr_d      = waddr_q;
    back_full_d  = back_full_q;
    front_d      = front_q;
    frame_done_d = last_s;
    swapped_d    = swap_s;

    if (accept_s) begin
      if (wr_pix_s == LAST_PIX) begin
        waddr_d = {PIX_AW{1'b0}};
      end else begin
        waddr_d = wr_pix_s + PIX_AW'(1'b1);
      end
    end else begin
      waddr_d = waddr_q;
    end

    if (swap_s) begin
      front_d     = ~front_q;
      back_full_d = 1'b0;
    end else if (DBL && last_s) begin
      back_full_d = 1'b1;
    end else begin
      back_full_d = back_full_q;
    end

    // Single-bank stores never stall; double-buffered stores stall on a full back bank.
    if (DBL) begin
      wr_ready_d = ~back_full_d;
    end else begin
      wr_ready_d = 1'b1;
    end
  end

  // Display counters: column, line repeat and stored line.
  always_comb begin
    v_sync_d = v_sync;
    bright_d = bright;
    col_d    = col_q;
    rep_d    = rep_q;
    line_d   = line_q;

    if (!v_sync) begin
      col_d  = {COL_W{1'b0}};
      rep_d  = {REP_W{1'b0}};
      line_d = {LINE_W{1'b0}};
    end else begin
      if (!h_sync) begin
        col_d = {COL_W{1'b0}};
      end else if (bright) begin
        // Saturate so an overlong active region repeats the last column.
        if (col_q == LAST_COL) begin
          col_d = col_q;
        end else begin
          col_d = col_q + COL_W'(1'b1);
        end
      end else if (br_fall_s) begin
        col_d = {COL_W{1'b0}};
      end else begin
        col_d = col_q;
      end

      if (br_fall_s) begin
        if (rep_q == LAST_REP) begin
          rep_d = {REP_W{1'b0}};
          if (line_q == LAST_LINE) begin
            line_d = {LINE_W{1'b0}};
          end else begin
            line_d = line_q + LINE_W'(1'b1);
          end
        end else begin
          rep_d  = rep_q + REP_W'(1'b1);
          line_d = line_q;
        end
      end else begin
        rep_d  = rep_q;
        line_d = line_q;
      end
    end
  end

  // Output pixel: blanked whenever the previous cycle was outside the active region.
  always_comb begin
    pixel_valid_d = bright;
    if (bright) begin
      pixel_out_d = rd_data_s;
    end else begin
      pixel_out_d = {PIXEL_W{1'b0}};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      waddr_q       <= {PIX_AW{1'b0}};
      back_full_q   <= 1'b0;
      front_q       <= 1'b0;
      wr_ready_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      swapped_q     <= 1'b0;
      v_sync_q      <= 1'b0;
      bright_q      <= 1'b0;
      col_q         <= {COL_W{1'b0}};
      rep_q         <= {REP_W{1'b0}};
      line_q        <= {LINE_W{1'b0}};
      pixel_out_q   <= {PIXEL_W{1'b0}};
      pixel_valid_q <= 1'b0;
    end else begin
      waddr_q       <= waddr_d;
      back_full_q   <= back_full_d;
      front_q       <= front_d;
      wr_ready_q    <= wr_ready_d;
      frame_done_q  <= frame_done_d;
      swapped_q     <= swapped_d;
      v_sync_q      <= v_sync_d;
      bright_q      <= bright_d;
      col_q         <= col_d;
      rep_q         <= rep_d;
      line_q        <= line_d;
      pixel_out_q   <= pixel_out_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign wr.wr_ready  = wr_ready_q;
  assign pixel_out    = pixel_out_q;
  assign pixel_valid  = pixel_valid_q;
  assign frame_done   = frame_done_q;
  assign swapped      = swapped_q;

endmodule
